// File: rtl/store_buffer_coalesce.sv
// Two-stage store buffer: speculative FIFO until commit, then a commit FIFO that drains to the D$.
// Same-word commits can merge into the commit-queue tail when COALESCE_EN is set.
module store_buffer_coalesce #(
  parameter int unsigned DEPTH_SPEC   = 4,
  parameter int unsigned DEPTH_COMMIT = 8,
  parameter int unsigned PLEN         = 56,
  parameter int unsigned XLEN         = 64,
  parameter int unsigned MATCH_LSB    = 3,
  parameter bit          COALESCE_EN  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              stall_st_pending_i,
  input  logic              valid_i,
  input  logic [PLEN-1:0]   paddr_i,
  input  logic [XLEN-1:0]   data_i,
  input  logic [XLEN/8-1:0] be_i,
  input  logic [1:0]        data_size_i,
  input  logic              valid_without_flush_i,
  input  logic              commit_i,
  output logic              ready_o,
  output logic              commit_ready_o,
  input  logic [11:0]       page_offset_i,
  output logic              page_offset_matches_o,
  output logic              no_st_pending_o,
  output logic              store_buffer_empty_o,
  output logic              data_req_o,
  input  logic              data_gnt_i,
  output logic [PLEN-1:0]   addr_o,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN/8-1:0] be_o,
  output logic [1:0]        size_o,
  output logic              coalesced_o
);

  localparam int unsigned BW  = XLEN / 8;
  localparam int unsigned OFF = $clog2(BW);
  localparam int unsigned SPW = $clog2(DEPTH_SPEC);
  localparam int unsigned CMW = $clog2(DEPTH_COMMIT);
  localparam int unsigned SCW = SPW + 1;
  localparam int unsigned CCW = CMW + 1;

  typedef struct packed {
    logic            valid;
    logic [PLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [BW-1:0]   be;
    logic [1:0]      size;
  } entry_t;

  entry_t          spec_q   [DEPTH_SPEC];
  entry_t          spec_d   [DEPTH_SPEC];
  entry_t          commit_q [DEPTH_COMMIT];
  entry_t          commit_d [DEPTH_COMMIT];
  logic [SPW-1:0]  spec_wptr_q, spec_wptr_d, spec_rptr_q, spec_rptr_d;
  logic [SCW-1:0]  spec_cnt_q, spec_cnt_d;
  logic [CMW-1:0]  cm_wptr_q, cm_wptr_d, cm_rptr_q, cm_rptr_d;
  logic [CCW-1:0]  cm_cnt_q, cm_cnt_d;

  entry_t          push_ent;
  entry_t          spec_head;
  entry_t          cm_head;
  entry_t          cm_tail;
  entry_t          merged;
  logic [CMW-1:0]  tail_idx;
  logic            merge;
  logic            drain_fire;
  logic            match_c;
  logic            unused_page_bits;

  assign push_ent   = '{valid: 1'b1, addr: paddr_i, data: data_i, be: be_i, size: data_size_i};
  assign spec_head  = spec_q[spec_rptr_q];
  assign cm_head    = commit_q[cm_rptr_q];
  assign tail_idx   = cm_wptr_q - CMW'(1);
  assign cm_tail    = commit_q[tail_idx];

  // With at least two entries queued the tail can never be the head being presented.
  assign merge = COALESCE_EN && commit_i && (cm_cnt_q >= CCW'(2)) && cm_tail.valid &&
                 (cm_tail.addr[PLEN-1:OFF] == spec_head.addr[PLEN-1:OFF]);

  always_comb begin
    merged = cm_tail;
    for (int unsigned b = 0; b < BW; b++) begin
      if (spec_head.be[b]) merged.data[8*b +: 8] = spec_head.data[8*b +: 8];
    end
    merged.be   = cm_tail.be | spec_head.be;
    merged.size = 2'(OFF);
  end

  assign data_req_o = cm_head.valid && !stall_st_pending_i;
  assign drain_fire = data_req_o && data_gnt_i;

  always_comb begin
    spec_d      = spec_q;
    spec_wptr_d = spec_wptr_q;
    spec_rptr_d = spec_rptr_q;
    commit_d    = commit_q;
    cm_wptr_d   = cm_wptr_q;
    cm_rptr_d   = cm_rptr_q;

    // Pop before push so a full-queue push+pop reuses the freed slot.
    if (commit_i) begin
      spec_d[spec_rptr_q].valid = 1'b0;
      spec_rptr_d = spec_rptr_q + SPW'(1);
    end
    if (valid_i) begin
      spec_d[spec_wptr_q] = push_ent;
      spec_wptr_d = spec_wptr_q + SPW'(1);
    end
    spec_cnt_d = spec_cnt_q + SCW'(valid_i) - SCW'(commit_i);
    if (flush_i) begin
      for (int unsigned i = 0; i < DEPTH_SPEC; i++) spec_d[i].valid = 1'b0;
      spec_wptr_d = spec_rptr_d;
      spec_cnt_d  = '0;
    end

    if (drain_fire) begin
      commit_d[cm_rptr_q].valid = 1'b0;
      cm_rptr_d = cm_rptr_q + CMW'(1);
    end
    if (commit_i) begin
      if (merge) begin
        commit_d[tail_idx] = merged;
      end else begin
        commit_d[cm_wptr_q]       = spec_head;
        commit_d[cm_wptr_q].valid = 1'b1;
        cm_wptr_d = cm_wptr_q + CMW'(1);
      end
    end
    cm_cnt_d = cm_cnt_q + CCW'(commit_i && !merge) - CCW'(drain_fire);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_q      <= '{default: '0};
      commit_q    <= '{default: '0};
      spec_wptr_q <= '0;
      spec_rptr_q <= '0;
      spec_cnt_q  <= '0;
      cm_wptr_q   <= '0;
      cm_rptr_q   <= '0;
      cm_cnt_q    <= '0;
    end else begin
      spec_q      <= spec_d;
      commit_q    <= commit_d;
      spec_wptr_q <= spec_wptr_d;
      spec_rptr_q <= spec_rptr_d;
      spec_cnt_q  <= spec_cnt_d;
      cm_wptr_q   <= cm_wptr_d;
      cm_rptr_q   <= cm_rptr_d;
      cm_cnt_q    <= cm_cnt_d;
    end
  end

  // Loads may alias any buffered store or the store whose address is arriving this cycle.
  always_comb begin
    match_c = valid_without_flush_i && (paddr_i[11:MATCH_LSB] == page_offset_i[11:MATCH_LSB]);
    for (int unsigned i = 0; i < DEPTH_SPEC; i++) begin
      if (spec_q[i].valid && (spec_q[i].addr[11:MATCH_LSB] == page_offset_i[11:MATCH_LSB]))
        match_c = 1'b1;
    end
    for (int unsigned i = 0; i < DEPTH_COMMIT; i++) begin
      if (commit_q[i].valid && (commit_q[i].addr[11:MATCH_LSB] == page_offset_i[11:MATCH_LSB]))
        match_c = 1'b1;
    end
  end

  assign unused_page_bits      = ^page_offset_i[MATCH_LSB-1:0];
  assign page_offset_matches_o = match_c;
  assign ready_o               = (spec_cnt_d < SCW'(DEPTH_SPEC)) || commit_i;
  assign commit_ready_o        = cm_cnt_q < CCW'(DEPTH_COMMIT);
  assign no_st_pending_o       = (cm_cnt_q == '0);
  assign store_buffer_empty_o  = (spec_cnt_q == '0) && (cm_cnt_q == '0);
  assign addr_o                = cm_head.addr;
  assign wdata_o               = cm_head.data;
  assign be_o                  = cm_head.be;
  assign size_o                = cm_head.size;
  assign coalesced_o           = merge;

  // A full commit queue may only take a commit that merges or coincides with a grant.
  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(flush_i && commit_i)) else $error("store buffer: flush together with commit");
      assert (!(commit_i && !commit_ready_o && !drain_fire && !merge))
        else $error("store buffer: commit into full commit queue");
    end
  end

endmodule

// File: tb/tb_store_buffer_coalesce.sv
// Directed bench for store_buffer_coalesce: one coalescing and one non-coalescing instance share stimulus.
module tb_store_buffer_coalesce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, stall, valid, vwf, commit, gnt;
  logic [55:0] paddr;
  logic [63:0] data;
  logic [7:0]  be;
  logic [1:0]  size;
  logic [11:0] page_off;

  logic        c_ready, c_cready, c_match, c_nost, c_empty, c_req, c_coal;
  logic [55:0] c_addr;
  logic [63:0] c_wdata;
  logic [7:0]  c_be;
  logic [1:0]  c_size;
  logic        n_ready, n_cready, n_match, n_nost, n_empty, n_req, n_coal;
  logic [55:0] n_addr;
  logic [63:0] n_wdata;
  logic [7:0]  n_be;
  logic [1:0]  n_size;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  store_buffer_coalesce #(.COALESCE_EN(1'b1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .stall_st_pending_i(stall),
    .valid_i(valid), .paddr_i(paddr), .data_i(data), .be_i(be), .data_size_i(size),
    .valid_without_flush_i(vwf), .commit_i(commit), .ready_o(c_ready),
    .commit_ready_o(c_cready), .page_offset_i(page_off), .page_offset_matches_o(c_match),
    .no_st_pending_o(c_nost), .store_buffer_empty_o(c_empty), .data_req_o(c_req),
    .data_gnt_i(gnt), .addr_o(c_addr), .wdata_o(c_wdata), .be_o(c_be), .size_o(c_size),
    .coalesced_o(c_coal)
  );

  store_buffer_coalesce #(.COALESCE_EN(1'b0)) u_n (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .stall_st_pending_i(stall),
    .valid_i(valid), .paddr_i(paddr), .data_i(data), .be_i(be), .data_size_i(size),
    .valid_without_flush_i(vwf), .commit_i(commit), .ready_o(n_ready),
    .commit_ready_o(n_cready), .page_offset_i(page_off), .page_offset_matches_o(n_match),
    .no_st_pending_o(n_nost), .store_buffer_empty_o(n_empty), .data_req_o(n_req),
    .data_gnt_i(gnt), .addr_o(n_addr), .wdata_o(n_wdata), .be_o(n_be), .size_o(n_size),
    .coalesced_o(n_coal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_push(input logic [55:0] a, input logic [63:0] d, input logic [7:0] b,
                          input logic [1:0] s);
    valid = 1'b1;
    paddr = a;
    data  = d;
    be    = b;
    size  = s;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; stall = 1'b0; valid = 1'b0; vwf = 1'b0; commit = 1'b0;
    gnt = 1'b0; paddr = '0; data = '0; be = '0; size = '0; page_off = '0;

    // Reset state, and the offset check staying combinational during reset
    #1;
    chk("rst_ready", 64'(c_ready), 64'd1);
    chk("rst_commit_ready", 64'(c_cready), 64'd1);
    chk("rst_no_st_pending", 64'(c_nost), 64'd1);
    chk("rst_empty", 64'(c_empty), 64'd1);
    chk("rst_data_req", 64'(c_req), 64'd0);
    chk("rst_coalesced", 64'(c_coal), 64'd0);
    vwf = 1'b1; paddr = 56'h018; page_off = 12'h01C;
    #1 chk("rst_match_inflight", 64'(c_match), 64'd1);
    page_off = 12'h020;
    #1 chk("rst_match_other_word", 64'(c_match), 64'd0);
    vwf = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Fill the speculative queue without committing
    for (int k = 0; k < 3; k++) begin
      set_push(56'h100 + 56'(8 * k), 64'(k), 8'hFF, 2'd3);
      cyc();
    end
    valid = 1'b0;
    #1 chk("spec3_ready", 64'(c_ready), 64'd1);
    set_push(56'h118, 64'd3, 8'hFF, 2'd3);
    cyc();
    valid = 1'b0;
    #1 chk("spec4_ready", 64'(c_ready), 64'd0);
    chk("spec4_empty", 64'(c_empty), 64'd0);
    chk("spec4_data_req", 64'(c_req), 64'd0);
    chk("spec4_no_st_pending", 64'(c_nost), 64'd1);
    commit = 1'b1;
    #1 chk("spec4_ready_with_commit", 64'(c_ready), 64'd1);
    commit = 1'b0;

    // Reset mid-operation drops the pending stores
    rst_n = 1'b0;
    #1 chk("midrst_empty", 64'(c_empty), 64'd1);
    chk("midrst_ready", 64'(c_ready), 64'd1);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single store: request appears the cycle after commit
    set_push(56'h1000, 64'hAA, 8'h01, 2'd0);
    cyc();
    valid = 1'b0; commit = 1'b1;
    #1 chk("single_req_before", 64'(c_req), 64'd0);
    cyc();
    commit = 1'b0; gnt = 1'b1;
    #1 chk("single_req", 64'(c_req), 64'd1);
    chk("single_addr", 64'(c_addr), 64'h1000);
    chk("single_wdata", c_wdata, 64'hAA);
    chk("single_be", 64'(c_be), 64'h01);
    chk("single_size", 64'(c_size), 64'd0);
    cyc();
    chk("single_no_st_pending", 64'(c_nost), 64'd1);
    chk("single_req_after", 64'(c_req), 64'd0);
    chk("single_empty", 64'(c_empty), 64'd1);

    // Coalescing: two held entries, then two half-word stores to the same word
    stall = 1'b1;
    set_push(56'h3000, 64'hA0A0, 8'hFF, 2'd3); cyc();
    set_push(56'h3008, 64'hB0B0, 8'hFF, 2'd3); cyc();
    set_push(56'h2000, 64'h11223344, 8'h0F, 2'd2); cyc();
    set_push(56'h2000, 64'h5566778800000000, 8'hF0, 2'd2); cyc();
    valid = 1'b0; commit = 1'b1;
    #1 chk("coal_commit_a", 64'(c_coal), 64'd0);
    cyc();
    cyc();
    chk("coal_commit_c1", 64'(c_coal), 64'd0);
    cyc();
    chk("coal_commit_c2", 64'(c_coal), 64'd1);
    chk("nocoal_commit_c2", 64'(n_coal), 64'd0);
    cyc();
    commit = 1'b0;
    #1 chk("coal_pulse_end", 64'(c_coal), 64'd0);
    chk("coal_stalled_req", 64'(c_req), 64'd0);
    chk("coal_no_st_pending", 64'(c_nost), 64'd0);
    stall = 1'b0;
    #1 chk("coal_d0_addr", 64'(c_addr), 64'h3000);
    chk("nocoal_d0_addr", 64'(n_addr), 64'h3000);
    cyc();
    chk("coal_d1_addr", 64'(c_addr), 64'h3008);
    chk("nocoal_d1_addr", 64'(n_addr), 64'h3008);
    cyc();
    chk("coal_d2_req", 64'(c_req), 64'd1);
    chk("coal_d2_addr", 64'(c_addr), 64'h2000);
    chk("coal_d2_be", 64'(c_be), 64'hFF);
    chk("coal_d2_wdata", c_wdata, 64'h5566778811223344);
    chk("coal_d2_size", 64'(c_size), 64'd3);
    chk("nocoal_d2_addr", 64'(n_addr), 64'h2000);
    chk("nocoal_d2_be", 64'(n_be), 64'h0F);
    chk("nocoal_d2_wdata", n_wdata, 64'h11223344);
    chk("nocoal_d2_size", 64'(n_size), 64'd2);
    cyc();
    chk("coal_d3_req", 64'(c_req), 64'd0);
    chk("coal_d3_no_st_pending", 64'(c_nost), 64'd1);
    chk("nocoal_d3_req", 64'(n_req), 64'd1);
    chk("nocoal_d3_be", 64'(n_be), 64'hF0);
    chk("nocoal_d3_wdata", n_wdata, 64'h5566778800000000);
    cyc();
    chk("nocoal_no_st_pending", 64'(n_nost), 64'd1);

    // Flush: speculative entries vanish, commit contents survive and drain
    stall = 1'b1;
    set_push(56'h5000, 64'h55, 8'hFF, 2'd3); cyc();
    valid = 1'b0; commit = 1'b1; cyc();
    commit = 1'b0;
    set_push(56'h6010, 64'h1, 8'hFF, 2'd3); cyc();
    set_push(56'h6020, 64'h2, 8'hFF, 2'd3); cyc();
    set_push(56'h6030, 64'h3, 8'hFF, 2'd3); cyc();
    valid = 1'b0; page_off = 12'h010;
    #1 chk("preflush_match_spec", 64'(c_match), 64'd1);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1 chk("flush_match_spec", 64'(c_match), 64'd0);
    chk("flush_ready", 64'(c_ready), 64'd1);
    chk("flush_empty", 64'(c_empty), 64'd0);
    chk("flush_no_st_pending", 64'(c_nost), 64'd0);
    page_off = 12'h000;
    #1 chk("flush_match_commit", 64'(c_match), 64'd1);
    vwf = 1'b1; paddr = 56'h7018; page_off = 12'h01C;
    #1 chk("flush_match_inflight", 64'(c_match), 64'd1);
    page_off = 12'h020;
    #1 chk("flush_match_none", 64'(c_match), 64'd0);
    vwf = 1'b0;
    stall = 1'b0;
    #1 chk("flush_drain_req", 64'(c_req), 64'd1);
    chk("flush_drain_addr", 64'(c_addr), 64'h5000);
    cyc();
    chk("flush_all_empty", 64'(c_empty), 64'd1);
    chk("nocoal_flush_all_empty", 64'(n_empty), 64'd1);

    // Fill the commit queue (pointers wrap), then commit and grant together while full
    stall = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      set_push(56'h8000 + 56'(8 * k), 64'h100 + 64'(k), 8'hFF, 2'd3);
      commit = (k > 0);
      if (k == 8) begin
        #1 chk("full7_commit_ready", 64'(c_cready), 64'd1);
      end
      cyc();
    end
    valid = 1'b0; commit = 1'b0;
    #1 chk("full_commit_ready", 64'(c_cready), 64'd0);
    chk("nocoal_full_commit_ready", 64'(n_cready), 64'd0);
    chk("full_spec_ready", 64'(c_ready), 64'd1);
    stall = 1'b0; commit = 1'b1;
    #1 chk("full_req", 64'(c_req), 64'd1);
    chk("full_head_addr", 64'(c_addr), 64'h8000);
    chk("full_coalesced", 64'(c_coal), 64'd0);
    cyc();
    commit = 1'b0;
    #1 chk("full_stays_full", 64'(c_cready), 64'd0);
    chk("nocoal_full_stays_full", 64'(n_cready), 64'd0);
    for (int k = 1; k <= 8; k++) begin
      chk("wrap_addr", 64'(c_addr), 64'h8000 + 64'(8 * k));
      chk("wrap_wdata", c_wdata, 64'h100 + 64'(k));
      chk("nocoal_wrap_addr", 64'(n_addr), 64'h8000 + 64'(8 * k));
      cyc();
    end
    chk("wrap_no_st_pending", 64'(c_nost), 64'd1);
    chk("wrap_empty", 64'(c_empty), 64'd1);
    chk("wrap_commit_ready", 64'(c_cready), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
